// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// The request is held until the access-complete acknowledge; read data is valid with that acknowledge.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of core_lapido: data-memory access FSM, flag register, branch/jump resolution, MEM/WB register.
// state  | meaning
// S_IDLE | no access in flight; a load/store at EX output launches the request and stalls
// S_BUSY | request outstanding, stall held until dmem_ack
// S_DONE | access complete, instruction retires from the load buffer
module mem_stage #(
  parameter int PC_WIDTH   = 32,
  parameter int FLAG_WIDTH = 6,
  parameter int ZERO_BIT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_mem_write_enable,
  input  logic [1:0]            in_wb_res_mux,
  input  logic                  in_reg_write_enable,
  input  logic                  in_fl_write_enable,
  input  logic                  in_is_branch,
  input  logic                  in_is_jump,
  input  logic                  in_branch_on_flag,
  input  logic                  in_sel_beq_bne,
  input  logic                  in_sel_jt_jf,
  input  logic [PC_WIDTH-1:0]   in_next_pc,
  input  logic [PC_WIDTH-1:0]   in_abs_addr,
  input  logic [31:0]           in_immediate,
  input  logic [31:0]           in_alu_out,
  input  logic [31:0]           in_mem_addr,
  input  logic [31:0]           in_mem_data,
  input  logic [FLAG_WIDTH-1:0] in_alu_flags,
  input  logic [4:0]            in_flag_addr,
  input  logic [4:0]            in_reg_dst,
  mem_stage_if.master           dmem,
  output logic                  stall,
  output logic                  pc_src,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic [FLAG_WIDTH-1:0] flags,
  output logic                  wb_reg_write_enable,
  output logic [4:0]            wb_reg_dst,
  output logic [31:0]           wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_access;
  logic                    w_stall;
  logic                    w_start;
  logic                    w_ack_busy;
  logic                    w_taken;
  logic                    w_flag_cond;
  logic [31:0]             w_flags_ext;
  logic [31:0]             w_wb_sel;

  logic                    r_dmem_req;
  logic                    r_dmem_we;
  logic [31:0]             r_dmem_addr;
  logic [31:0]             r_dmem_wdata;
  logic [31:0]             r_load_buf;
  logic [FLAG_WIDTH-1:0]   r_flags;
  logic                    r_wb_we;
  logic [4:0]              r_wb_dst;
  logic [31:0]             r_wb_data;

  assign w_access = in_mem_write_enable | (in_wb_res_mux == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_ack_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (dmem.dmem_ack) begin
          w_ack_busy  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_load_buf   <= '0;
    end else begin
      if (w_start) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= in_mem_write_enable;
        r_dmem_addr  <= in_mem_addr;
        r_dmem_wdata <= in_mem_data;
      end else if (w_ack_busy) begin
        r_dmem_req   <= 1'b0;
        r_load_buf   <= dmem.dmem_rdata;
      end
    end
  end

  // Flag update is gated by stall so a stalled instruction cannot write the flags twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_flags <= '0;
    else if (!w_stall && in_fl_write_enable) r_flags <= in_alu_flags;
  end

  // Flag indices past FLAG_WIDTH fall into the zero padding.
  assign w_flags_ext = 32'(r_flags);
  assign w_flag_cond = w_flags_ext[in_flag_addr];

  always_comb begin
    w_taken = 1'b0;
    if (in_is_jump) begin
      w_taken = 1'b1;
    end else if (in_is_branch) begin
      if (in_branch_on_flag) w_taken = w_flag_cond ^ in_sel_jt_jf;
      else                   w_taken = in_alu_flags[ZERO_BIT] ^ in_sel_beq_bne;
    end
  end

  always_comb begin
    w_wb_sel = in_alu_out;
    case (in_wb_res_mux)
      2'b00:   w_wb_sel = in_alu_out;
      2'b01:   w_wb_sel = r_load_buf;
      2'b10:   w_wb_sel = 32'(in_next_pc);
      default: w_wb_sel = in_immediate;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
    end else if (w_stall) begin
      r_wb_we   <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we   <= in_reg_write_enable;
      r_wb_dst  <= in_reg_dst;
      r_wb_data <= w_wb_sel;
    end
  end

  // Combinational outputs are forced low during reset even if EX still presents an access.
  assign stall     = w_stall & ~rst;
  assign pc_src    = w_taken & ~w_stall & ~rst;
  assign pc_target = pc_src ? in_abs_addr : '0;
  assign flags     = r_flags;

  assign dmem.dmem_req   = r_dmem_req;
  assign dmem.dmem_we    = r_dmem_we;
  assign dmem.dmem_addr  = r_dmem_addr;
  assign dmem.dmem_wdata = r_dmem_wdata;

  assign wb_reg_write_enable = r_wb_we;
  assign wb_reg_dst          = r_wb_dst;
  assign wb_data             = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: write-back results go through a scoreboard queue,
// memory timing, stall, flag and branch outputs are checked directly.
module tb_mem_stage;
  logic        clk;
  logic        rst;
  logic        in_mem_write_enable;
  logic [1:0]  in_wb_res_mux;
  logic        in_reg_write_enable;
  logic        in_fl_write_enable;
  logic        in_is_branch;
  logic        in_is_jump;
  logic        in_branch_on_flag;
  logic        in_sel_beq_bne;
  logic        in_sel_jt_jf;
  logic [31:0] in_next_pc;
  logic [31:0] in_abs_addr;
  logic [31:0] in_immediate;
  logic [31:0] in_alu_out;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_data;
  logic [5:0]  in_alu_flags;
  logic [4:0]  in_flag_addr;
  logic [4:0]  in_reg_dst;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [5:0]  flags;
  logic        wb_reg_write_enable;
  logic [4:0]  wb_reg_dst;
  logic [31:0] wb_data;

  mem_stage_if u_if ();

  mem_stage #(.PC_WIDTH(32), .FLAG_WIDTH(6), .ZERO_BIT(0)) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_mem_write_enable (in_mem_write_enable),
    .in_wb_res_mux       (in_wb_res_mux),
    .in_reg_write_enable (in_reg_write_enable),
    .in_fl_write_enable  (in_fl_write_enable),
    .in_is_branch        (in_is_branch),
    .in_is_jump          (in_is_jump),
    .in_branch_on_flag   (in_branch_on_flag),
    .in_sel_beq_bne      (in_sel_beq_bne),
    .in_sel_jt_jf        (in_sel_jt_jf),
    .in_next_pc          (in_next_pc),
    .in_abs_addr         (in_abs_addr),
    .in_immediate        (in_immediate),
    .in_alu_out          (in_alu_out),
    .in_mem_addr         (in_mem_addr),
    .in_mem_data         (in_mem_data),
    .in_alu_flags        (in_alu_flags),
    .in_flag_addr        (in_flag_addr),
    .in_reg_dst          (in_reg_dst),
    .dmem                (u_if),
    .stall               (stall),
    .pc_src              (pc_src),
    .pc_target           (pc_target),
    .flags               (flags),
    .wb_reg_write_enable (wb_reg_write_enable),
    .wb_reg_dst          (wb_reg_dst),
    .wb_data             (wb_data)
  );

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  wb_t sb_exp;
  int  n_checks = 0;
  int  n_errors = 0;
  int  ns;
  int  nr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every register write leaving MEM/WB must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && wb_reg_write_enable) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 64'(wb_reg_dst), 64'h3f);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("wb_dst", 64'(wb_reg_dst), 64'(sb_exp.dst));
        chk("wb_data", 64'(wb_data), 64'(sb_exp.data));
      end
    end
  end

  task automatic clr_in();
    in_mem_write_enable = 0; in_wb_res_mux = 2'b00; in_reg_write_enable = 0;
    in_fl_write_enable = 0; in_is_branch = 0; in_is_jump = 0; in_branch_on_flag = 0;
    in_sel_beq_bne = 0; in_sel_jt_jf = 0; in_next_pc = 0; in_abs_addr = 0;
    in_immediate = 0; in_alu_out = 0; in_mem_addr = 0; in_mem_data = 0;
    in_alu_flags = 0; in_flag_addr = 0; in_reg_dst = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Plays the memory: acks after ack_wait BUSY cycles without ack; returns at the DONE-cycle negedge.
  task automatic run_mem(input int ack_wait, input logic [31:0] rdata, input logic exp_we,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         output int n_stall, output int n_req);
    int  waited;
    bit  done;
    waited = 0; done = 0; n_stall = 0; n_req = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        n_stall++;
        chk("pc_src_in_stall", 64'(pc_src), 64'd0);
        if (u_if.dmem_req) begin
          n_req++;
          chk("dmem_we", 64'(u_if.dmem_we), 64'(exp_we));
          chk("dmem_addr", 64'(u_if.dmem_addr), 64'(exp_addr));
          chk("dmem_wdata", 64'(u_if.dmem_wdata), 64'(exp_wdata));
          chk("wb_bubble", 64'(wb_reg_write_enable), 64'd0);
          if (waited == ack_wait) begin
            u_if.dmem_ack = 1'b1;
            u_if.dmem_rdata = rdata;
          end else begin
            waited++;
            u_if.dmem_ack = 1'b0;
          end
        end else begin
          u_if.dmem_ack = 1'b0;
        end
      end
    end
    u_if.dmem_ack = 1'b0;
    u_if.dmem_rdata = 32'h0;
    if (!done) chk("mem_timeout", 64'd1, 64'd0);
    chk("req_dropped_done", 64'(u_if.dmem_req), 64'd0);
  endtask

  task automatic chk_br(input string tag, input logic exp_src, input logic [31:0] exp_tgt);
    @(negedge clk);
    chk({tag, "_src"}, 64'(pc_src), 64'(exp_src));
    chk({tag, "_tgt"}, 64'(pc_target), 64'(exp_tgt));
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    u_if.dmem_ack = 1'b0;
    u_if.dmem_rdata = 32'h0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(u_if.dmem_req), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_pc_src", 64'(pc_src), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_wb_we", 64'(wb_reg_write_enable), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    rst = 1'b0;

    // Load, ack on the first BUSY cycle
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b01; in_reg_write_enable = 1; in_reg_dst = 5'd5;
    in_mem_addr = 32'h40; in_alu_out = 32'h999;
    sb_q.push_back('{dst: 5'd5, data: 32'hDEADBEEF});
    run_mem(0, 32'hDEADBEEF, 1'b0, 32'h40, 32'h0, ns, nr);
    chk("load_stall_cycles", 64'(ns), 64'd2);
    chk("load_req_cycles", 64'(nr), 64'd1);

    // ALU op writing flags, then jt/jf on flag 2
    next_cyc(); clr_in();
    in_fl_write_enable = 1; in_alu_flags = 6'b000100; in_reg_write_enable = 1;
    in_reg_dst = 5'd3; in_alu_out = 32'h55;
    sb_q.push_back('{dst: 5'd3, data: 32'h55});
    @(negedge clk);
    chk("alu_stall", 64'(stall), 64'd0);
    next_cyc(); clr_in();
    in_is_branch = 1; in_branch_on_flag = 1; in_flag_addr = 5'd2; in_abs_addr = 32'h200;
    chk_br("jt_f2", 1'b1, 32'h200);
    chk("flags_set", 64'(flags), 64'b000100);
    next_cyc(); in_sel_jt_jf = 1;
    chk_br("jf_f2", 1'b0, 32'h0);
    // Flag test uses the pre-update register value
    next_cyc(); in_sel_jt_jf = 0; in_fl_write_enable = 1; in_alu_flags = 6'b000000;
    chk_br("jt_pre_upd", 1'b1, 32'h200);
    next_cyc(); in_fl_write_enable = 0;
    chk_br("jt_post_upd", 1'b0, 32'h0);
    chk("flags_cleared", 64'(flags), 64'd0);

    // beq / bne / jump with branch
    next_cyc(); clr_in();
    in_is_branch = 1; in_alu_flags = 6'b000001; in_abs_addr = 32'h80;
    chk_br("beq", 1'b1, 32'h80);
    next_cyc(); in_sel_beq_bne = 1;
    chk_br("bne", 1'b0, 32'h0);
    next_cyc(); clr_in();
    in_is_jump = 1; in_is_branch = 1; in_abs_addr = 32'h300;
    chk_br("jump_prio", 1'b1, 32'h300);

    // Flag index boundaries
    next_cyc(); clr_in(); in_fl_write_enable = 1; in_alu_flags = 6'b100000;
    next_cyc(); clr_in(); in_is_branch = 1; in_branch_on_flag = 1; in_flag_addr = 5'd5;
    in_abs_addr = 32'h500;
    chk_br("jt_f5", 1'b1, 32'h500);
    next_cyc(); in_flag_addr = 5'd7;
    chk_br("jt_f7", 1'b0, 32'h0);
    next_cyc(); in_sel_jt_jf = 1;
    chk_br("jf_f7", 1'b1, 32'h500);

    // Spurious ack in IDLE
    next_cyc(); clr_in(); u_if.dmem_ack = 1'b1; u_if.dmem_rdata = 32'h11111111;
    @(negedge clk);
    chk("spur_stall", 64'(stall), 64'd0);
    next_cyc(); u_if.dmem_ack = 1'b0;
    @(negedge clk);
    chk("spur_req", 64'(u_if.dmem_req), 64'd0);
    chk("spur_stall2", 64'(stall), 64'd0);

    // Store with three wait cycles
    next_cyc(); clr_in();
    in_mem_write_enable = 1; in_mem_addr = 32'h10; in_mem_data = 32'h1234;
    run_mem(3, 32'h0, 1'b1, 32'h10, 32'h1234, ns, nr);
    chk("store_stall_cycles", 64'(ns), 64'd5);
    chk("store_req_cycles", 64'(nr), 64'd4);

    // next_pc and immediate write-back
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b10; in_reg_write_enable = 1; in_reg_dst = 5'd7; in_next_pc = 32'h1004;
    sb_q.push_back('{dst: 5'd7, data: 32'h1004});
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b11; in_reg_write_enable = 1; in_reg_dst = 5'd8; in_immediate = 32'hCAFE;
    sb_q.push_back('{dst: 5'd8, data: 32'hCAFE});

    // Load carrying a jump: redirect held off until DONE
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b01; in_reg_write_enable = 1; in_reg_dst = 5'd9;
    in_mem_addr = 32'h44; in_is_jump = 1; in_abs_addr = 32'h400;
    sb_q.push_back('{dst: 5'd9, data: 32'h0BADF00D});
    run_mem(1, 32'h0BADF00D, 1'b0, 32'h44, 32'h0, ns, nr);
    chk("ldj_stall_cycles", 64'(ns), 64'd3);
    chk("ldj_pc_src_done", 64'(pc_src), 64'd1);
    chk("ldj_pc_tgt_done", 64'(pc_target), 64'h400);

    // Reset while BUSY, then a clean load
    next_cyc(); clr_in(); in_fl_write_enable = 1; in_alu_flags = 6'b010010;
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b01; in_reg_write_enable = 1; in_reg_dst = 5'd10; in_mem_addr = 32'h48;
    @(negedge clk);
    @(negedge clk);
    chk("busy_req", 64'(u_if.dmem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy_req", 64'(u_if.dmem_req), 64'd0);
    chk("rst_busy_stall", 64'(stall), 64'd0);
    chk("rst_busy_flags", 64'(flags), 64'd0);
    @(negedge clk);
    clr_in();
    rst = 1'b0;
    next_cyc(); clr_in();
    in_wb_res_mux = 2'b01; in_reg_write_enable = 1; in_reg_dst = 5'd11; in_mem_addr = 32'h4C;
    sb_q.push_back('{dst: 5'd11, data: 32'hA5A5A5A5});
    run_mem(0, 32'hA5A5A5A5, 1'b0, 32'h4C, 32'h0, ns, nr);
    chk("rld_stall_cycles", 64'(ns), 64'd2);
    chk("rld_req_cycles", 64'(nr), 64'd1);
    next_cyc(); clr_in();
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach its end, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the core_lapido 5-stage pipeline. It sits directly downstream of EX_stage and consumes its outputs: ALU result, memory address and data, flags, branch and jump controls, and destination register. It drives a handshaked data-memory port, owns the 6-bit flag register, resolves branches and jumps toward IF, and holds the MEM/WB pipeline register feeding write-back.

Parameters:
PC_WIDTH, 32, width of next_pc and of the branch/jump target
FLAG_WIDTH, 6, number of ALU flags and width of the flag register
ZERO_BIT, 0, index of the zero flag in in_alu_flags, used by beq/bne

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_mem_write_enable  in  1  store
in_wb_res_mux  in  2  00 alu_out, 01 load data, 10 next_pc, 11 immediate
in_reg_write_enable  in  1  write-back enable
in_fl_write_enable  in  1  update the flag register
in_is_branch / in_is_jump  in  1 each  instruction class
in_branch_on_flag  in  1  1=jt/jf class, 0=beq/bne class
in_sel_beq_bne  in  1  0=beq, 1=bne
in_sel_jt_jf  in  1  0=jt, 1=jf
in_next_pc  in  PC_WIDTH  return address
in_abs_addr  in  PC_WIDTH  branch/jump target
in_immediate, in_alu_out, in_mem_addr, in_mem_data  in  32 each  data from EX
in_alu_flags  in  FLAG_WIDTH  flags computed by EX
in_flag_addr  in  5  flag index tested by jt/jf
in_reg_dst  in  5  destination register
dmem_req  out  1  memory request, registered
dmem_we  out  1  1=write, registered
dmem_addr, dmem_wdata  out  32 each  registered
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  access complete
stall  out  1  freeze IF/ID/EX and their pipeline registers
pc_src  out  1  redirect PC and flush IF/ID/EX
pc_target  out  PC_WIDTH  redirect address
flags  out  FLAG_WIDTH  current flag register
wb_reg_write_enable  out  1  MEM/WB register
wb_reg_dst  out  5  MEM/WB register
wb_data  out  32  MEM/WB register, selected result

Behaviour:
- Reset asserted: every output and register is 0, FSM goes to IDLE. Reset mid-access drops dmem_req immediately and discards the transfer.
- access = in_mem_write_enable OR (in_wb_res_mux==01).
- FSM states:
  - IDLE: if access is set, latch addr/wdata/we into dmem_* and set dmem_req at this edge, then go to BUSY. stall=access (combinational). dmem_ack arriving in IDLE is ignored.
  - BUSY: hold dmem_req and stall=1. On dmem_ack, capture dmem_rdata into a load buffer, clear dmem_req, and go to DONE.
  - DONE: stall=0, the instruction retires into MEM/WB using the load buffer, and the FSM returns to IDLE. Upstream guarantees a new instruction at EX output in the following cycle.
- Minimum memory instruction latency is 3 cycles: detect, BUSY with same-cycle ack, DONE. Each extra wait cycle without ack adds one cycle.
- MEM/WB register:
  - Updates every edge.
  - Loads a bubble (wb_reg_write_enable=0, dst=0, data=0) while stall=1.
  - Otherwise loads wb_reg_dst=in_reg_dst and wb_reg_write_enable=in_reg_write_enable.
  - wb_data = mux(in_wb_res_mux): alu_out, load buffer, zero-extended in_next_pc, in_immediate.
- Flag register: on an edge where stall=0 and in_fl_write_enable=1, flags <= in_alu_flags.
- Branch resolution (combinational, only when stall=0):
  - in_is_jump=1 gives pc_src=1. Jump has priority over branch.
  - in_is_branch with in_branch_on_flag=1: cond = flags[in_flag_addr]; indices >= FLAG_WIDTH read 0. taken = cond XOR in_sel_jt_jf.
  - in_is_branch with in_branch_on_flag=0: cond = in_alu_flags[ZERO_BIT]. taken = cond XOR in_sel_beq_bne.
  - The flag test reads the pre-update flag register, even if the same instruction sets in_fl_write_enable.
  - pc_target = in_abs_addr. pc_target is 0 whenever pc_src=0.
- Branches and jumps never access memory. If access and a branch/jump are both present, access wins and pc_src is suppressed until DONE.

Test Plan:
- Reset during BUSY (dmem_req=1) -> dmem_req, stall, and flags go to 0 asynchronously; next load starts cleanly from IDLE.
- Load, wb_res_mux=01, addr 0x40, ack on first BUSY cycle with rdata 0xDEADBEEF -> stall high for 2 cycles; dmem_req high 1 cycle, dmem_we=0; wb_data=0xDEADBEEF, wb_reg_write_enable=1 one cycle after DONE.
- Store addr 0x10, data 0x1234, ack delayed 3 cycles -> dmem_we=1, dmem_addr=0x10, dmem_wdata=0x1234 held stable; stall high 5 cycles; MEM/WB holds bubbles; no register write.
- ALU op with fl_write_enable=1, alu_flags=6'b000100, then jt on flag_addr=2 -> flags=000100; jt gives pc_src=1, pc_target=abs_addr; jf on the same flag gives pc_src=0.
- beq with in_alu_flags[0]=1, abs_addr=0x80 -> pc_src=1, pc_target=0x80; bne with the same flags -> pc_src=0; jump with is_branch also set -> pc_src=1.
- jt with flag_addr=7 -> pc_src=0; jf with flag_addr=7 -> pc_src=1. A spurious dmem_ack in IDLE causes no state change.
